// File: rtl/demorgan_pkg.sv
// Shared types and sizes for the De Morgan gate-pair sweep controller.
package demorgan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    COMPARE,
    DONE
  } state_t;

  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned VEC_W       = 2;
  localparam int unsigned HOLD_W      = 4;
  localparam int unsigned ERR_W       = 3;

endpackage

// File: rtl/demorgan_sweep_ctrl.sv
// Clocked sequencer that sweeps all four (a,b) vectors onto the De Morgan
// gate pair, waits HOLD_CYCLES per vector, checks both implementations
// against the golden NAND and reports error count / first failing vector.
module demorgan_sweep_ctrl
  import demorgan_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4   // legal range 1..15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             y_lhs,
  input  logic             y_rhs,
  output logic             a_o,
  output logic             b_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             fail_valid,
  output logic [VEC_W-1:0] fail_vec
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [VEC_W-1:0]  VEC_LAST  = VEC_W'(NUM_VECTORS - 1);

  state_t              r_state,      w_state;
  logic [VEC_W-1:0]    r_vec,        w_vec;
  logic [HOLD_W-1:0]   r_hold,       w_hold;
  logic                r_busy,       w_busy;
  logic                r_done,       w_done;
  logic                r_pass,       w_pass;
  logic [ERR_W-1:0]    r_err,        w_err;
  logic                r_fail_valid, w_fail_valid;
  logic [VEC_W-1:0]    r_fail_vec,   w_fail_vec;
  logic                w_golden;
  logic                w_vec_fail;

  // State and result registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_hold       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= '0;
    end else begin
      r_state      <= w_state;
      r_vec        <= w_vec;
      r_hold       <= w_hold;
      r_busy       <= w_busy;
      r_done       <= w_done;
      r_pass       <= w_pass;
      r_err        <= w_err;
      r_fail_valid <= w_fail_valid;
      r_fail_vec   <= w_fail_vec;
    end
  end

  // Next-state and next-output logic; done/pass are computed on the
  // COMPARE->DONE transition so they are visible during the DONE cycle.
  always_comb begin
    w_state      = r_state;
    w_vec        = r_vec;
    w_hold       = r_hold;
    w_busy       = r_busy;
    w_done       = 1'b0;
    w_pass       = r_pass;
    w_err        = r_err;
    w_fail_valid = r_fail_valid;
    w_fail_vec   = r_fail_vec;
    w_golden     = ~(r_vec[1] & r_vec[0]);
    w_vec_fail   = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_vec        = '0;
          w_hold       = '0;
          w_err        = '0;
          w_fail_valid = 1'b0;
          w_fail_vec   = '0;
          w_pass       = 1'b0;
          w_busy       = 1'b1;
          w_state      = SETTLE;
        end
      end
      SETTLE: begin
        w_hold = r_hold + HOLD_W'(1);
        if (r_hold == HOLD_LAST) begin
          w_state = COMPARE;
        end
      end
      COMPARE: begin
        w_vec_fail = (y_lhs != w_golden) || (y_rhs != w_golden);
        if (w_vec_fail) begin
          w_err = r_err + ERR_W'(1);
          if (!r_fail_valid) begin
            w_fail_valid = 1'b1;
            w_fail_vec   = r_vec;
          end
        end
        if (r_vec == VEC_LAST) begin
          w_done  = 1'b1;
          w_pass  = (w_err == '0);
          w_state = DONE;
        end else begin
          w_vec   = r_vec + VEC_W'(1);
          w_hold  = '0;
          w_state = SETTLE;
        end
      end
      DONE: begin
        w_busy  = 1'b0;
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign a_o        = r_vec[1];
  assign b_o        = r_vec[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err;
  assign fail_valid = r_fail_valid;
  assign fail_vec   = r_fail_vec;

endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Directed bench for demorgan_sweep_ctrl: HOLD_CYCLES=4 and HOLD_CYCLES=1
// instances driving behavioural gate models with selectable faults.
module tb_demorgan_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start4, start1;
  logic [1:0] mode4, mode1;   // 0: correct, 1: y_rhs stuck-at-0, 2: y_lhs = a&b

  logic       a4, b4, busy4, done4, pass4, fv4;
  logic [2:0] err4;
  logic [1:0] fvec4;
  logic       ylhs4, yrhs4;

  logic       a1, b1, busy1, done1, pass1, fv1;
  logic [2:0] err1;
  logic [1:0] fvec1;
  logic       ylhs1, yrhs1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign ylhs4 = (mode4 == 2'd2) ? (a4 & b4) : ~(a4 & b4);
  assign yrhs4 = (mode4 == 2'd1) ? 1'b0 : (~a4 | ~b4);
  assign ylhs1 = (mode1 == 2'd2) ? (a1 & b1) : ~(a1 & b1);
  assign yrhs1 = (mode1 == 2'd1) ? 1'b0 : (~a1 | ~b1);

  demorgan_sweep_ctrl #(.HOLD_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .y_lhs(ylhs4), .y_rhs(yrhs4),
    .a_o(a4), .b_o(b4), .busy(busy4), .done(done4), .pass(pass4),
    .err_cnt(err4), .fail_valid(fv4), .fail_vec(fvec4)
  );

  demorgan_sweep_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .y_lhs(ylhs1), .y_rhs(yrhs1),
    .a_o(a1), .b_o(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_valid(fv1), .fail_vec(fvec1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full sweep on the HOLD_CYCLES=4 instance; optional extra start pulse
  // sampled at edge repulse_edge (0 = none).
  task automatic sweep4(input string name, input logic exp_pass, input logic [2:0] exp_err,
                        input logic exp_fv, input logic [1:0] exp_fvec, input int repulse_edge);
    start4 = 1'b1;
    tick();                       // edge 1
    start4 = 1'b0;
    check({name, ":busy_e1"}, busy4, 1);
    check({name, ":vec_e1"}, {a4, b4}, 0);
    check({name, ":done_e1"}, done4, 0);
    for (int e = 2; e <= 21; e++) begin
      start4 = (e == repulse_edge);
      tick();
      start4 = 1'b0;
      if (e <= 20) begin
        check($sformatf("%s:vec_e%0d", name, e), {a4, b4}, (e - 1) / 5);
        check($sformatf("%s:done_e%0d", name, e), done4, 0);
        check($sformatf("%s:busy_e%0d", name, e), busy4, 1);
      end
    end
    check({name, ":done_e21"}, done4, 1);
    check({name, ":busy_e21"}, busy4, 1);
    check({name, ":pass"}, pass4, exp_pass);
    check({name, ":err_cnt"}, err4, exp_err);
    check({name, ":fail_valid"}, fv4, exp_fv);
    check({name, ":fail_vec"}, fvec4, exp_fvec);
    tick();                       // edge 22
    check({name, ":done_e22"}, done4, 0);
    check({name, ":busy_e22"}, busy4, 0);
    check({name, ":pass_hold"}, pass4, exp_pass);
    check({name, ":err_hold"}, err4, exp_err);
  endtask

  initial begin
    int seen_done;
    rst_n  = 1'b0;
    start4 = 1'b0;
    start1 = 1'b0;
    mode4  = 2'd0;
    mode1  = 2'd0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst:a_b", {a4, b4}, 0);
    check("rst:busy", busy4, 0);
    check("rst:done", done4, 0);
    check("rst:pass", pass4, 0);
    check("rst:err", err4, 0);
    check("rst:fv", fv4, 0);
    check("rst:fvec", fvec4, 0);
    tick();

    mode4 = 2'd0;
    sweep4("good", 1'b1, 3'd0, 1'b0, 2'd0, 0);
    tick();
    mode4 = 2'd1;
    sweep4("rhs_sa0", 1'b0, 3'd3, 1'b1, 2'd0, 0);
    tick();
    mode4 = 2'd2;
    sweep4("lhs_and", 1'b0, 3'd4, 1'b1, 2'd0, 0);
    tick();
    mode4 = 2'd0;
    sweep4("repulse", 1'b1, 3'd0, 1'b0, 2'd0, 7);
    tick();

    // Reset during vector 2 after two failing vectors have accumulated.
    mode4  = 2'd2;
    start4 = 1'b1;
    tick();                       // edge 1
    start4 = 1'b0;
    for (int e = 2; e <= 12; e++) tick();
    check("midrst:vec2", {a4, b4}, 2);
    check("midrst:err_before", err4, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst:a_b", {a4, b4}, 0);
    check("midrst:busy", busy4, 0);
    check("midrst:done", done4, 0);
    check("midrst:pass", pass4, 0);
    check("midrst:err", err4, 0);
    check("midrst:fv", fv4, 0);
    check("midrst:fvec", fvec4, 0);
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done4 !== 1'b0 || busy4 !== 1'b0) seen_done++;
    end
    check("midrst:no_done_or_busy", seen_done, 0);
    mode4 = 2'd0;
    sweep4("after_rst", 1'b1, 3'd0, 1'b0, 2'd0, 0);

    // HOLD_CYCLES=1, start held high: back-to-back sweeps.
    mode1  = 2'd2;
    start1 = 1'b1;
    tick();                       // edge 1
    check("h1:busy_e1", busy1, 1);
    check("h1:vec_e1", {a1, b1}, 0);
    for (int e = 2; e <= 8; e++) begin
      tick();
      check($sformatf("h1:vec_e%0d", e), {a1, b1}, (e - 1) / 2);
      check($sformatf("h1:done_e%0d", e), done1, 0);
    end
    tick();                       // edge 9
    check("h1:done_e9", done1, 1);
    check("h1:err_run1", err1, 4);
    check("h1:pass_run1", pass1, 0);
    check("h1:fv_run1", fv1, 1);
    check("h1:fvec_run1", fvec1, 0);
    mode1 = 2'd0;
    tick();                       // edge 10
    check("h1:busy_e10", busy1, 0);
    check("h1:done_e10", done1, 0);
    check("h1:err_e10", err1, 4);
    tick();                       // edge 11
    check("h1:busy_e11", busy1, 1);
    check("h1:err_clr", err1, 0);
    check("h1:fv_clr", fv1, 0);
    check("h1:pass_clr", pass1, 0);
    for (int e = 12; e <= 18; e++) begin
      tick();
      check($sformatf("h1:done_e%0d", e), done1, 0);
    end
    start1 = 1'b0;
    tick();                       // edge 19
    check("h1:done_e19", done1, 1);
    check("h1:pass_run2", pass1, 1);
    check("h1:err_run2", err1, 0);
    check("h1:fv_run2", fv1, 0);
    tick();                       // edge 20
    check("h1:busy_e20", busy1, 0);
    tick();                       // edge 21
    check("h1:idle_e21", busy1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demorgan_sweep_ctrl.md
# demorgan_sweep_ctrl

Self-checking sequencer for the one-bit De Morgan gate pair. On `start` it sweeps all four (a, b) combinations onto the gates, waits a programmable settle time per vector, and compares both implementations (NAND form and OR-of-inverts form) against a golden NAND value. It counts mismatches, latches the first failing vector and reports pass/fail with a `done` pulse. It sits between the lab top level (switches/LEDs) and the two gate instances, replacing free-running stimulus with clocked, repeatable sequencing.

## Interface
- `HOLD_CYCLES`, 4: settle cycles per vector before comparison; legal range 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  run request; sampled only in IDLE.
- `y_lhs`  in  1  output of the ~(a&b) implementation.
- `y_rhs`  in  1  output of the ~a|~b implementation.
- `a_o`  out  1  drive to both gates' `a`; equals `vec[1]`.
- `b_o`  out  1  drive to both gates' `b`; equals `vec[0]`.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE state.
- `done`  out  1  one-cycle pulse at end of sweep.
- `pass`  out  1  `err_cnt==0`; valid from `done` until the next accepted `start`.
- `err_cnt`  out  3  number of failing vectors, 0..4.
- `fail_valid`  out  1  at least one vector failed.
- `fail_vec`  out  2  {a,b} of the first failing vector.

## Operation
- Internal registers: `state`, `vec[1:0]`, `hold_cnt[3:0]`.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE: if `start`, set `vec`=0, `hold_cnt`=0, `err_cnt`=0, `fail_valid`=0, `fail_vec`=0, `pass`=0; go to SETTLE. Otherwise hold all result outputs.
- SETTLE: increment `hold_cnt`. On `hold_cnt==HOLD_CYCLES-1`, go to COMPARE.
- COMPARE (one cycle):
  - Compute golden `g = ~(a_o & b_o)`.
  - Vector fails if `y_lhs!=g` or `y_rhs!=g`.
  - On failure, increment `err_cnt`. If `fail_valid==0`, set `fail_valid`=1 and `fail_vec`=`vec`.
  - If `vec==3`, go to DONE. Otherwise `vec`+1, `hold_cnt`=0, go to SETTLE.
- DONE: `done`=1 and `pass`=(`err_cnt`==0), registered so both are visible in the DONE cycle. Return to IDLE next cycle.
- `start` while `busy` is ignored; there is no queuing.
- `start` held high across DONE→IDLE begins a new sweep one cycle later (back-to-back runs allowed).
- `vec` never wraps past 3 within a run. `err_cnt` saturation is not needed, since its maximum is 4.

## Timing
- All outputs are registered. Reset values: `a_o`=0, `b_o`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_valid`=0, `fail_vec`=0, state IDLE.
- Edge 1 is the edge that samples `start`. `busy` and the vector 0 drive are visible after edge 1.
- Each vector occupies HOLD_CYCLES+1 cycles (SETTLE ×HOLD_CYCLES, then COMPARE ×1).
- COMPARE samples the gate outputs after HOLD_CYCLES cycles of stable drive.
- `done` is high after edge 4·(HOLD_CYCLES+1)+1, which is edge 21 for the default. `busy` falls one edge later.
- Reset asserted mid-sweep: next edge forces all reset values. The partial result is discarded and no `done` is produced.
- `y_lhs`/`y_rhs` are sampled only in COMPARE; glitches during SETTLE have no effect.

## Structure
- Shared package `demorgan_pkg`: state enum (IDLE, SETTLE, COMPARE, DONE), `NUM_VECTORS`=4, `VEC_W`=2, `HOLD_W`=4.
- Single module. The hold counter is small enough to stay inline, so no sub-module.
- The top level instantiates this block plus the two gate modules. The gates remain purely combinational.

## Test plan
- Correct gates, HOLD_CYCLES=4, pulse `start` → `a_o,b_o` step 00,01,10,11, each held 5 cycles; `done` after edge 21; `pass`=1, `err_cnt`=0, `fail_valid`=0.
- `y_rhs` forced to 0 (stuck-at-0) → fails on vectors 00, 01 and 10; `err_cnt`=3, `fail_vec`=00, `fail_valid`=1, `pass`=0.
- `y_lhs` replaced by a&b (missing inverter) → all four vectors fail; `err_cnt`=4, `fail_vec`=00.
- `start` re-pulsed at cycle 7 while `busy` → ignored; `done` still after edge 21 with unchanged results.
- `rst_n`=0 for one cycle during vector 2 → next cycle all outputs 0 and state IDLE; a fresh `start` then completes normally with `pass`=1.
- HOLD_CYCLES=1 with `start` held high continuously → back-to-back sweeps, `done` after edge 9, next `busy` rise after edge 11, results cleared at restart.
